// File: rtl/amber48_fetch.sv
// amber48 instruction fetch stage: owns the fetch PC, issues in-order word requests and
// buffers returned instructions in a small in-order queue feeding the decoder.

package amber48_pkg;
    localparam int XLEN = 48;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [47:0]     instr;
    } amber48_decode_in_s;
endpackage

module amber48_fetch #(
    parameter int              XLEN     = amber48_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    output logic                                imem_req_o,
    output logic [XLEN-1:0]                     imem_addr_o,
    input  logic                                imem_gnt_i,
    input  logic                                imem_rvalid_i,
    input  logic [47:0]                         imem_rdata_i,
    input  logic                                redirect_i,
    input  logic [XLEN-1:0]                     redirect_pc_i,
    output amber48_pkg::amber48_decode_in_s     fetch_o,
    input  logic                                fetch_ready_i
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DEPTH + 1) + 1;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  q_pc    [DEPTH];
    logic [47:0]      q_instr [DEPTH];
    logic [DEPTH-1:0] q_filled;
    logic [AW-1:0]    head_q;
    logic [AW-1:0]    tail_q;
    logic [AW-1:0]    fill_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    unfilled_q;
    logic [DW-1:0]    discard_q;
    logic             active_q;

    logic head_valid;
    logic out_valid;
    logic pop;
    logic req;
    logic issue;
    logic drop;
    logic fill;

    always_comb begin
        head_valid = active_q && (count_q != '0) && q_filled[head_q];
        out_valid  = rst_ni && head_valid && !redirect_i;
        pop        = out_valid && fetch_ready_i;
        // a head popped this cycle frees its slot for a same-cycle issue
        req        = rst_ni && active_q && !redirect_i &&
                     ((count_q != CW'(DEPTH)) || pop);
        issue      = req && imem_gnt_i;
        drop       = imem_rvalid_i && (discard_q != '0);
        fill       = imem_rvalid_i && (discard_q == '0) && (unfilled_q != '0) && !redirect_i;
    end

    assign imem_req_o  = req;
    assign imem_addr_o = pc_q;

    always_comb begin
        fetch_o = '0;
        if (out_valid) begin
            fetch_o.valid = 1'b1;
            fetch_o.pc    = q_pc[head_q];
            fetch_o.instr = q_instr[head_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q       <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
            discard_q  <= '0;
            q_filled   <= '0;
            active_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else begin
            active_q <= 1'b1;
            if (redirect_i) begin
                pc_q       <= redirect_pc_i;
                head_q     <= '0;
                tail_q     <= '0;
                fill_q     <= '0;
                count_q    <= '0;
                unfilled_q <= '0;
                q_filled   <= '0;
                // every unfilled entry still owes a response; one may be arriving right now
                discard_q  <= discard_q + DW'(unfilled_q) - DW'(imem_rvalid_i);
            end else begin
                if (pop) begin
                    q_filled[head_q] <= 1'b0;
                    head_q           <= head_q + AW'(1);
                end
                if (issue) begin
                    q_pc[tail_q]     <= pc_q;
                    q_filled[tail_q] <= 1'b0;
                    tail_q           <= tail_q + AW'(1);
                    pc_q             <= pc_q + XLEN'(1);
                end
                if (drop) begin
                    discard_q <= discard_q - DW'(1);
                end else if (fill) begin
                    q_instr[fill_q]  <= imem_rdata_i;
                    q_filled[fill_q] <= 1'b1;
                    fill_q           <= fill_q + AW'(1);
                end
                count_q    <= count_q + CW'(issue) - CW'(pop);
                unfilled_q <= unfilled_q + CW'(issue) - CW'(fill);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && active_q && imem_rvalid_i && (discard_q == '0)) begin
            if (!redirect_i) begin
                fill_has_entry : assert (unfilled_q != '0);
            end else begin
                discard_no_underflow : assert (unfilled_q != '0);
            end
        end
    end

endmodule

// File: tb/tb_amber48_fetch.sv
// Bench for amber48_fetch: directed scenarios plus a randomized phase, checked against an
// in-order instruction-stream model and an in-order memory responder.

module tb_amber48_fetch;
    import amber48_pkg::*;

    localparam logic [47:0] WRAP_PC = 48'hFFFF_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_ni, gnt, rvalid, redirect, ready;
    logic [47:0]        rdata, redirect_pc;
    logic               req;
    logic [47:0]        addr;
    amber48_decode_in_s fo;

    logic               req_w, rvalid_w;
    logic [47:0]        addr_w, rdata_w;
    amber48_decode_in_s fo_w;

    amber48_fetch #(.XLEN(48), .RESET_PC(48'h0), .DEPTH(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .fetch_o(fo), .fetch_ready_i(ready)
    );

    amber48_fetch #(.XLEN(48), .RESET_PC(WRAP_PC), .DEPTH(2)) dut_w (
        .clk_i(clk), .rst_ni(rst_ni),
        .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_gnt_i(1'b1),
        .imem_rvalid_i(rvalid_w), .imem_rdata_i(rdata_w),
        .redirect_i(1'b0), .redirect_pc_i(48'h0),
        .fetch_o(fo_w), .fetch_ready_i(1'b1)
    );

    typedef struct {
        logic [47:0] a;
        int          due;
    } rsp_t;

    rsp_t pend[$];

    int                 n_cmp, n_bad, cyc, lat_lo, lat_hi, n_acc, n_w, at, n0;
    logic [47:0]        exp_pc, exp_w;
    logic [47:0]        w_first [3];
    logic               obs_req;
    logic [47:0]        obs_addr;
    amber48_decode_in_s obs_f;
    int                 obs_cyc;
    logic               hold_prev, wait_prev, w_nv;
    amber48_decode_in_s f_prev;
    logic [47:0]        addr_prev, w_na, target;

    function automatic logic [47:0] memf(input logic [47:0] a);
        return 48'h100000_000000 + a;
    endfunction

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Observe the settled cycle, update the models, then advance one clock and drive responses.
    task automatic cycle();
        int   due;
        rsp_t r;
        #2;
        obs_req  = req;
        obs_addr = addr;
        obs_f    = fo;
        obs_cyc  = cyc;
        if (rst_ni) begin
            if (wait_prev && !redirect) begin
                chk("req_held", req, 1'b1);
                chk("addr_held", addr, addr_prev);
            end
            if (hold_prev && !redirect) chk("fetch_held", fo, f_prev);
            if (!fo.valid) chk("idle_zero", {fo.pc, fo.instr}, 96'h0);
            if (redirect) begin
                chk("redir_valid", fo.valid, 1'b0);
                chk("redir_req", req, 1'b0);
            end
            if (fo.valid && ready) begin
                chk("out_pc", fo.pc, exp_pc);
                chk("out_instr", fo.instr, memf(exp_pc));
                exp_pc = exp_pc + 48'd1;
                n_acc++;
            end
            if (redirect) exp_pc = redirect_pc;
            if (rvalid) void'(pend.pop_front());
            if (req && gnt) begin
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
                r.a   = addr;
                r.due = due;
                pend.push_back(r);
            end
            if (fo_w.valid) begin
                chk("w_pc", fo_w.pc, exp_w);
                chk("w_instr", fo_w.instr, memf(exp_w));
                if (n_w < 3) w_first[n_w] = fo_w.pc;
                n_w++;
                exp_w = exp_w + 48'd1;
            end
            w_nv      = req_w;
            w_na      = addr_w;
            hold_prev = fo.valid && !ready && !redirect;
            f_prev    = fo;
            wait_prev = req && !gnt && !redirect;
            addr_prev = addr;
        end else begin
            pend.delete();
            exp_pc    = 48'h0;
            exp_w     = WRAP_PC;
            n_w       = 0;
            w_nv      = 1'b0;
            hold_prev = 1'b0;
            wait_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        rvalid = 1'b0;
        rdata  = 48'h0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = memf(pend[0].a);
        end
        rvalid_w = w_nv;
        rdata_w  = memf(w_na);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        cycle();
        rst_ni = 1'b1;
        cyc    = 0;
    endtask

    task automatic wait_valid(input int budget, input string tag, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (obs_f.valid) begin
                at_cyc = obs_cyc;
                break;
            end
        end
        chk({tag, "_seen"}, obs_f.valid, 1'b1);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; n_acc = 0; n_w = 0;
        rst_ni = 1'b0; gnt = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = 48'h0;
        rvalid = 1'b0; rdata = 48'h0; rvalid_w = 1'b0; rdata_w = 48'h0;
        lat_lo = 1; lat_hi = 1; exp_pc = 48'h0; exp_w = WRAP_PC;
        hold_prev = 1'b0; wait_prev = 1'b0; w_nv = 1'b0; w_na = 48'h0;
        @(posedge clk);
        #1;

        // reset, then free-running stream with 1-cycle memory
        repeat (2) begin
            cycle();
            chk("rst_req", obs_req, 1'b0);
            chk("rst_fetch", obs_f, '0);
        end
        rst_ni = 1'b1;
        cyc    = 0;
        cycle();
        chk("c0_req", obs_req, 1'b0);
        chk("c0_valid", obs_f.valid, 1'b0);
        wait_valid(12, "t1_first", at);
        chk("t1_latency", at, 3);
        repeat (8) begin
            cycle();
            chk("t1_stream", obs_f.valid, 1'b1);
        end
        chk("wrap_pc0", w_first[0], WRAP_PC);
        chk("wrap_pc1", w_first[1], 48'h0);
        chk("wrap_pc2", w_first[2], 48'h1);

        // decoder stall with the queue fully allocated
        ready = 1'b0;
        do_reset();
        wait_valid(12, "t2_first", at);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cycle();
            chk("t2_hold_valid", obs_f.valid, 1'b1);
            chk("t2_hold_pc", obs_f.pc, 48'h0);
            chk("t2_req_off", obs_req, 1'b0);
            chk("t2_addr", obs_addr, 48'h2);
        end
        ready = 1'b1;
        n0 = n_acc;
        repeat (6) cycle();
        chk("t2_resume_cnt", n_acc - n0, 6);

        // redirect with two requests in flight, 3-cycle memory
        lat_lo = 3; lat_hi = 3;
        do_reset();
        repeat (3) cycle();
        redirect = 1'b1; redirect_pc = 48'h400;
        cycle();
        redirect = 1'b0;
        wait_valid(15, "t3_first", at);
        chk("t3_pc", obs_f.pc, 48'h400);
        chk("t3_instr", obs_f.instr, memf(48'h400));
        chk("t3_latency", at, 8);

        // redirect coinciding with a response and a valid head
        ready = 1'b0; lat_lo = 2; lat_hi = 2;
        do_reset();
        repeat (4) cycle();
        target = {16'($urandom), $urandom};
        ready = 1'b1; redirect = 1'b1; redirect_pc = target;
        cycle();
        chk("t4_rvalid_seen", rvalid === 1'b0 || rvalid === 1'b1, 1'b1);
        redirect = 1'b0;
        wait_valid(15, "t4_first", at);
        chk("t4_pc", obs_f.pc, target);
        chk("t4_instr", obs_f.instr, memf(target));
        chk("t4_latency", at, 8);

        // grant withheld at PC 7
        lat_lo = 1; lat_hi = 1; gnt = 1'b1;
        do_reset();
        repeat (3) cycle();
        gnt = 1'b0; redirect = 1'b1; redirect_pc = 48'h7;
        cycle();
        redirect = 1'b0;
        repeat (4) begin
            cycle();
            chk("t5_req", obs_req, 1'b1);
            chk("t5_addr", obs_addr, 48'h7);
        end
        gnt = 1'b1;
        cycle();
        chk("t5_issue_addr", obs_addr, 48'h7);
        wait_valid(10, "t5_first", at);
        chk("t5_pc", obs_f.pc, 48'h7);

        // randomized grants, latencies, stalls and redirects
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 2500; i++) begin
            gnt      = ($urandom_range(9, 0) < 7);
            ready    = ($urandom_range(9, 0) < 6);
            redirect = ($urandom_range(99, 0) < 3);
            if ($urandom_range(3, 0) == 0)
                redirect_pc = WRAP_PC - 48'($urandom_range(2, 0));
            else
                redirect_pc = {16'($urandom), $urandom};
            cycle();
        end
        redirect = 1'b0; gnt = 1'b1; ready = 1'b1; lat_lo = 1; lat_hi = 1;
        n0 = n_acc;
        repeat (30) cycle();
        chk("t6_drain", (n_acc - n0) >= 20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
